// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM level decoder.
package pdm_pkg;

  typedef enum logic {
    FILL,
    RUN
  } pdm_state_e;

  localparam int unsigned PDM_SYNC_STAGES = 2;

  // Right shift that maps a full-window ones count onto the level width.
  function automatic int unsigned pdm_scale_shift(input int unsigned win_log2,
                                                  input int unsigned level_w);
    return win_log2 - level_w;
  endfunction

endpackage

// File: rtl/pdm_level_decoder_sync.sv
// PDM input sampling stage: STAGES flops in series, async active-low reset to 0.
module pdm_in_sync #(
  parameter int unsigned STAGES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  if (STAGES > 1) begin : g_multi
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end else begin : g_single
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= d_i;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pdm_level_decoder.sv
// Recovers the level behind a pulse-density stream by counting ones per 2^WIN_LOG2 window.
// Define PDM_IN_SYNC_EN to sample PDM_IN through a 2-flop synchronizer instead of one register.
module pdm_level_decoder
  import pdm_pkg::*;
#(
  parameter int unsigned LEVEL_W  = 4,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic               FPGA_CLK,
  input  logic               FPGA_RST_N,
  input  logic               PDM_IN,
  input  logic               DEC_EN,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               LEVEL_VALID,
  output logic               LOCKED,
  output logic               STUCK_HI
);

`ifdef PDM_IN_SYNC_EN
  localparam int unsigned SYNC_STAGES = PDM_SYNC_STAGES;
`else
  localparam int unsigned SYNC_STAGES = 1;
`endif
  localparam int unsigned SHIFT = pdm_scale_shift(WIN_LOG2, LEVEL_W);

  logic                s;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WIN_LOG2:0]   acc_q, acc_d;
  logic [WIN_LOG2:0]   total;
  pdm_state_e          state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                valid_q, valid_d;
  logic                stuck_q, stuck_d;

  pdm_in_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (FPGA_CLK),
    .rst_ni(FPGA_RST_N),
    .d_i   (PDM_IN),
    .q_o   (s)
  );

  assign total = acc_q + {{WIN_LOG2{1'b0}}, s};

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      wcnt_q  <= '0;
      acc_q   <= '0;
      state_q <= FILL;
      level_q <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    state_d = state_q;
    level_d = level_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    if (!DEC_EN) begin
      // Disable discards any partial window; LEVEL/STUCK_HI keep their last report.
      wcnt_d  = '0;
      acc_d   = '0;
      state_d = FILL;
    end else begin
      wcnt_d = wcnt_q + WIN_LOG2'(1);
      if (wcnt_q == '1) begin
        acc_d   = '0;
        state_d = RUN;
        valid_d = 1'b1;
        if (total[WIN_LOG2]) begin
          level_d = '1;
          stuck_d = 1'b1;
        end else begin
          level_d = total[WIN_LOG2-1 -: LEVEL_W];
          stuck_d = 1'b0;
        end
      end else begin
        acc_d = total;
      end
    end
  end

  assign LEVEL       = level_q;
  assign LEVEL_VALID = valid_q;
  assign LOCKED      = (state_q == RUN);
  assign STUCK_HI    = stuck_q;

endmodule

// File: tb/tb_pdm_level_decoder.sv
// Randomized/directed bench for pdm_level_decoder against a window-sum reference model.
module tb_pdm_level_decoder;

  localparam int unsigned LW  = 4;
  localparam int unsigned WL  = 4;
  localparam int          N   = 1 << WL;
  localparam int          MODW = 1 << LW;
`ifdef PDM_IN_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int HMAX = 4096;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          pdm   = 1'b0;
  logic          en    = 1'b0;
  logic [LW-1:0] level;
  logic          valid, locked, stuck;

  pdm_level_decoder #(
    .LEVEL_W (LW),
    .WIN_LOG2(WL)
  ) dut (
    .FPGA_CLK   (clk),
    .FPGA_RST_N (rst_n),
    .PDM_IN     (pdm),
    .DEC_EN     (en),
    .LEVEL      (level),
    .LEVEL_VALID(valid),
    .LOCKED     (locked),
    .STUCK_HI   (stuck)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;
  int run_len = 0;
  int last_v  = 0;
  int mod_acc = 0;
  bit pdm_h [HMAX];
  int mod_h [HMAX];
  bit exp_v, exp_lock, exp_stk;
  int exp_lvl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  // One clock: drive at negedge, predict from history after the posedge, compare at +1.
  task automatic tick(input bit p, input int m, input bit en_v, input bit r);
    int  sum;
    int  idx;
    bit  same;
    @(negedge clk);
    pdm   = p;
    en    = en_v;
    rst_n = r;
    @(posedge clk);
    e++;
    if (!r) begin
      pdm_h[e] = 1'b0;
      mod_h[e] = -1;
      run_len  = 0;
      exp_v    = 1'b0;
      exp_lock = 1'b0;
      exp_lvl  = 0;
      exp_stk  = 1'b0;
    end else begin
      pdm_h[e] = p;
      mod_h[e] = m;
      if (!en_v) begin
        run_len  = 0;
        exp_v    = 1'b0;
        exp_lock = 1'b0;
      end else begin
        run_len++;
        exp_lock = (run_len >= N);
        exp_v    = (run_len % N == 0);
        if (exp_v) begin
          sum = 0;
          for (int j = 0; j < N; j++) begin
            idx = e - j - D;
            if (idx >= 1) sum += int'(pdm_h[idx]);
          end
          exp_stk = (sum == N);
          exp_lvl = exp_stk ? (MODW - 1) : (sum >> (WL - LW));
        end
      end
    end
    #1;
    check("valid",  valid,  exp_v);
    check("locked", locked, exp_lock);
    check("level",  level,  exp_lvl);
    check("stuck",  stuck,  exp_stk);
    if (exp_v) begin
      if (run_len > N) check("spacing", e - last_v, N);
      last_v = e;
      same = 1'b1;
      for (int j = 0; j < N; j++) begin
        idx = e - j - D;
        if (idx < 1 || mod_h[idx] != mod_h[e - D]) same = 1'b0;
      end
      if (same && e - D >= 1 && mod_h[e - D] >= 0) check("exact", level, mod_h[e - D]);
    end
  endtask

  task automatic mod_run(input int lvl, input int cycles, input bit en_v);
    int s;
    for (int i = 0; i < cycles; i++) begin
      s       = mod_acc + lvl;
      mod_acc = s % MODW;
      tick(s >= MODW, lvl, en_v, 1'b1);
    end
  endtask

  // Advance the modulator with decoding on until the model's window phase reaches ph.
  task automatic mod_align(input int lvl, input int ph);
    int guard = 0;
    while (run_len % N != ph && guard < 2 * N) begin
      mod_run(lvl, 1, 1'b1);
      guard++;
    end
    check("align", run_len % N, ph);
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) mod_h[i] = -1;

    #1;
    check("rst_level", level, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_stuck", stuck, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, -1, 1'b0, 1'b0);
    tick(1'b0, -1, 1'b0, 1'b1);

    mod_run(5, 70, 1'b1);
    mod_run(0, 50, 1'b1);
    mod_run(15, 50, 1'b1);

    for (int i = 0; i < 2 * N + 3; i++) tick(1'b1, -1, 1'b1, 1'b1);
    for (int i = 0; i < 2 * N; i++)     tick(1'b0, -1, 1'b1, 1'b1);

    mod_run(7, 40, 1'b1);
    mod_align(7, 10);
    mod_run(7, 3, 1'b0);
    mod_run(7, 40, 1'b1);

    mod_align(9, N - 1);
    mod_run(9, 1, 1'b0);
    mod_run(9, 40, 1'b1);

    mod_run(11, 23, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", valid, 0);
    check("arst_locked", locked, 0);
    check("arst_stuck", stuck, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, -1, 1'b1, 1'b0);
    mod_run(11, 45, 1'b1);

    mod_align(3, 0);
    mod_run(3, 7, 1'b1);
    mod_run(12, 45, 1'b1);

    for (int blk = 0; blk < 6; blk++) begin
      int dens;
      dens = $urandom_range(0, 16);
      for (int i = 0; i < 100; i++)
        tick($urandom_range(0, 15) < dens, -1, $urandom_range(0, 99) >= 3, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pdm_level_decoder.md
Name: pdm_level_decoder

Overview:
- Receive end of the LED brightness modulator path: takes the 1-bit pulse-density stream produced by the first-order accumulator modulator and recovers the level that drove it.
- Counts '1' samples over a fixed window of 2^WIN_LOG2 clocks, scales the count to LEVEL_W bits, and publishes it with a one-cycle valid strobe.
- Used for loop-back self-test of the LED brightness path and for reading density-coded signals from neighbouring boards.

Parameters:
- LEVEL_W, 4, width of the recovered level. Must match the modulator input width.
- WIN_LOG2, 4, window length is 2^WIN_LOG2 clocks. Legal range: LEVEL_W <= WIN_LOG2 <= 16.

Ports:
- FPGA_CLK  input  1  system clock; all logic rises on this edge.
- FPGA_RST_N  input  1  asynchronous, active-low reset.
- PDM_IN  input  1  pulse-density bitstream.
- DEC_EN  input  1  decode enable. Low holds the block in the FILL state, cleared.
- LEVEL  output  LEVEL_W  recovered level.
- LEVEL_VALID  output  1  one-cycle pulse when LEVEL is updated.
- LOCKED  output  1  high once at least one full window has completed since enable.
- STUCK_HI  output  1  high when the last window was all ones (over-range).

Behaviour:
- Reset (asynchronous, FPGA_RST_N=0):
  - LEVEL=0, LEVEL_VALID=0, LOCKED=0, STUCK_HI=0.
  - Window counter WCNT=0, ones accumulator ACC=0, state=FILL.
- Sample: S is the sampled PDM_IN (see Optional Feature for sampling path).
- WCNT is WIN_LOG2 bits and increments every enabled cycle, wrapping naturally from 2^WIN_LOG2-1 to 0.
- ACC is WIN_LOG2+1 bits so it can hold the full count 2^WIN_LOG2.
- Normal cycles (WCNT != max): ACC <= ACC + S.
- End-of-window cycle (WCNT == max):
  - TOTAL = ACC + S.
  - ACC <= 0, so the next window starts clean with no carry-over.
  - Next cycle: LEVEL <= scaled TOTAL and LEVEL_VALID = 1 for exactly one cycle.
- Scaling: LEVEL = TOTAL >> (WIN_LOG2-LEVEL_W), truncating. If TOTAL == 2^WIN_LOG2, LEVEL saturates to all ones and STUCK_HI=1. Otherwise STUCK_HI=0. STUCK_HI is updated together with LEVEL.
- States:
  - FILL: counting the first window; LOCKED=0. At the first end-of-window, go to RUN.
  - RUN: LOCKED=1; valid pulse every 2^WIN_LOG2 cycles.
- DEC_EN:
  - DEC_EN=0 in any state: synchronous clear of WCNT and ACC, state=FILL, LOCKED=0, no valid pulse. LEVEL and STUCK_HI hold their last values.
  - DEC_EN rising edge: counting starts that cycle.
  - DEC_EN falling on the end-of-window cycle: that window is discarded, with no valid pulse.
- Latency: PDM_IN to LEVEL_VALID is (sync depth + 1) cycles after the last sample of the window.
- Exactness: for a first-order modulator with 2^LEVEL_W wrap and WIN_LOG2 = LEVEL_W, any aligned or unaligned window yields exactly the input level.
- Mid-window reset: abandons the partial count. No stale valid pulse after reset release.

Optional Feature:
- PDM_IN_SYNC_EN defined: PDM_IN passes through a 2-flop synchronizer reset to 0; sync depth = 2. Used for off-board or asynchronous sources.
- Not defined: PDM_IN is registered once; sync depth = 1. The source must be on FPGA_CLK.

Decomposition:
- Package pdm_pkg:
  - State enum {FILL, RUN}.
  - Constant PDM_SYNC_STAGES=2.
  - Helper function for the scale shift, WIN_LOG2-LEVEL_W.
- Sub-module pdm_in_sync: input synchronizer (1 or 2 stages per the macro), async active-low reset.
- Window counter, accumulator, FSM and output registers stay in the top module.

Test Plan:
- Loop-back with the modulator, input 5, WIN_LOG2=4: after LOCKED, every LEVEL_VALID shows LEVEL=5, spaced exactly 16 cycles apart. Repeat for levels 0 and 15.
- PDM_IN held 1, WIN_LOG2=4: first pulse gives LEVEL=15, STUCK_HI=1. Then PDM_IN held 0: next pulse gives LEVEL=0, STUCK_HI=0.
- WIN_LOG2=6, modulator input 9: LEVEL=9 every 64 cycles. No pulse before the first 64 enabled cycles; LOCKED rises with the first pulse.
- DEC_EN dropped at WCNT=10, re-raised 3 cycles later: no pulse for the broken window, LOCKED=0 until a full 16-cycle window completes, and LEVEL holds its old value meanwhile.
- FPGA_RST_N asserted mid-window, asynchronous to the clock: all outputs go to 0 immediately; after release, first valid pulse only after a complete window plus sync depth.
- Modulator level switched from 3 to 12 mid-window: the straddling window reports a value between 3 and 12; the following window reports exactly 12.
